// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: shared FSM state type and round-robin pick helper for delay_scheduler
package delay_sched_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} sched_state_t;
  localparam int MAX_REQ = 8;
  // First asserted index at or after p, wrapping at n; returns p when nothing is asserted
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p, input logic [3:0] n);
    logic [3:0] idx;
    rr_pick = p;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, p} + 4'(i);
      idx = idx >= n ? idx - n : idx;
      if (4'(i) < n && r[idx[2:0]]) rr_pick = idx[2:0];
    end
  endfunction
endpackage

// File: rtl/delay_scheduler_prescaler.sv
// tick_prescaler: clock-enable tick every DIV cycles while en, restartable via clr
//   clk, reset (async, active-high), clr (restart count), en (count enable), tick (one-cycle pulse)
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(DIV);
  logic [PW-1:0] pcnt_q, pcnt_d;
  assign tick = en && pcnt_q == PW'(DIV - 1);
  // Held at zero whenever disabled so every enable window starts a full period
  assign pcnt_d = (clr || !en || tick) ? '0 : pcnt_q + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) pcnt_q <= '0;
    else pcnt_q <= pcnt_d;
endmodule

// File: rtl/delay_scheduler.sv
// delay_scheduler: round-robin sharing of one tick-based delay counter among N_REQ requesters
//   clk, reset (async, active-high); req[N_REQ] request levels; dly[N_REQ*DLY_W] per-requester delays in ticks
//   grant one-hot owner; done one-cycle completion pulse; busy counter owned; tick prescaler pulse
module delay_scheduler
  import delay_sched_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10_000,
  parameter int N_REQ   = 4,
  parameter int DLY_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DLY_W-1:0] dly,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  generate
    if (CLK_HZ % TICK_HZ != 0 || DIV < 2 || N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_cfg
      $error("delay_scheduler: bad CLK_HZ/TICK_HZ/N_REQ configuration");
    end
  endgenerate
  sched_state_t     state_q;
  logic [N_REQ-1:0] grant_q, done_q, pick_oh_d;
  logic [2:0]       owner_q, rr_ptr_q, pick_d, next_ptr_d;
  logic [DLY_W-1:0] cnt_q, dly_d;
  logic             tick_w, owner_req_d;
  always_comb begin
    pick_d    = rr_pick(8'(req), rr_ptr_q, 4'(N_REQ));
    dly_d     = '0;
    pick_oh_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_oh_d[i] = pick_d == 3'(i);
      if (pick_d == 3'(i)) dly_d = dly[i*DLY_W +: DLY_W];
    end
    // grant_q is the owner's one-hot mask, so this is the owner's req alone
    owner_req_d = |(req & grant_q);
    next_ptr_d  = owner_q == 3'(N_REQ - 1) ? 3'd0 : owner_q + 3'd1;
  end
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == IDLE),
    .en   (state_q == COUNT),
    .tick (tick_w)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          owner_q <= pick_d;
          grant_q <= pick_oh_d;
          cnt_q   <= dly_d;
          // A zero delay completes on the grant edge itself
          done_q  <= dly_d == '0 ? pick_oh_d : '0;
          state_q <= dly_d == '0 ? DONE : COUNT;
        end
        COUNT: if (!owner_req_d) begin
          grant_q  <= '0;
          rr_ptr_q <= next_ptr_d;
          state_q  <= IDLE;
        end else if (tick_w) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DLY_W'(1)) begin
            done_q  <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          grant_q  <= '0;
          done_q   <= '0;
          rr_ptr_q <= next_ptr_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = state_q != IDLE;
  assign tick  = tick_w;
endmodule

// File: tb/tb_delay_scheduler.sv
// tb_delay_scheduler: directed scenarios checked against a cycle-level behavioural model
module tb_delay_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int DIV = 10;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dly = '0;
  logic [N-1:0] grant, done;
  logic busy, tick;
  int checks = 0, failures = 0, cyc = 0, nticks = 0;
  int g_own[$], g_cyc[$], d_own[$], d_cyc[$];
  logic [N-1:0] pg = '0;
  int m_own = -1, m_el = 0, m_tgt = 0, m_ptr = 0;
  bit m_dn = 0;

  delay_scheduler #(.CLK_HZ(100), .TICK_HZ(10), .N_REQ(N), .DLY_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .dly(dly),
    .grant(grant), .done(done), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int dly_of(input int i);
    return int'(dly[i*W +: W]);
  endfunction

  // Model: owner, cycles elapsed since its grant, target = dly*DIV cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own = -1; m_el = 0; m_tgt = 0; m_ptr = 0; m_dn = 0;
    end else if (m_own < 0) begin
      int pk;
      pk = -1;
      for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) pk = (m_ptr + k) % N;
      if (pk >= 0) begin
        m_own = pk; m_tgt = dly_of(pk) * DIV; m_el = 0; m_dn = (m_tgt == 0);
      end
    end else if (m_dn) begin
      m_ptr = (m_own + 1) % N; m_own = -1; m_dn = 0;
    end else if (!req[m_own]) begin
      m_ptr = (m_own + 1) % N; m_own = -1;
    end else begin
      m_el++;
      m_dn = (m_el == m_tgt);
    end
  end

  // Per-cycle compare plus event logging, sampled 1 time unit after the edge
  always @(posedge clk) begin
    cyc++;
    #1;
    chk("grant", grant, m_own >= 0 ? (1 << m_own) : 0);
    chk("done", done, (m_own >= 0 && m_dn) ? (1 << m_own) : 0);
    chk("busy", busy, m_own >= 0);
    chk("tick", tick, (m_own >= 0 && !m_dn && (m_el % DIV) == DIV - 1) ? 1 : 0);
    if (grant != 0 && pg == 0) begin g_own.push_back(oh2i(grant)); g_cyc.push_back(cyc); end
    if (done != 0) begin d_own.push_back(oh2i(done)); d_cyc.push_back(cyc); end
    if (tick) nticks++;
    pg = grant;
  end

  task automatic clear_logs();
    g_own.delete(); g_cyc.delete(); d_own.delete(); d_cyc.delete(); nticks = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    clear_logs();
  endtask

  task automatic set_dly(input int i, input int v);
    dly[i*W +: W] = W'(v);
  endtask

  task automatic wait_done(input int idx, input int budget, input bit drop);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (done[idx]) ok = 1;
    end
    chk($sformatf("done%0d_seen", idx), ok, 1);
    if (drop) req[idx] = 0;
  endtask

  task automatic wait_grant(input int idx, input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (grant[idx]) ok = 1;
    end
    chk($sformatf("grant%0d_seen", idx), ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    clear_logs();
    // 1: single request, dly=3 -> 30 cycles, 3 ticks
    set_dly(1, 3); req[1] = 1;
    wait_grant(1, 10);
    chk("t1_grant_val", grant, 4'b0010);
    chk("t1_model_tgt", m_tgt, 30);
    wait_done(1, 100, 1);
    chk("t1_owner", g_own[0], 1);
    chk("t1_latency", d_cyc[0] - g_cyc[0], 30);
    chk("t1_ticks", nticks, 3);
    // 2: simultaneous requests dly=1 -> 0,1,2,3 each 10 cycles, one idle cycle between
    do_reset();
    for (int i = 0; i < N; i++) set_dly(i, 1);
    req = '1;
    for (int i = 0; i < N; i++) wait_done(i, 60, 1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_order%0d", i), g_own[i], i);
      chk($sformatf("t2_lat%0d", i), d_cyc[i] - g_cyc[i], 10);
    end
    for (int i = 0; i < N - 1; i++) chk($sformatf("t2_gap%0d", i), g_cyc[i+1] - d_cyc[i], 2);
    // 3: dly=0 -> grant and done on the same single cycle, no tick
    do_reset();
    set_dly(2, 0); req[2] = 1;
    wait_done(2, 10, 1);
    chk("t3_grant_val", grant, 4'b0100);
    chk("t3_same_cycle", d_cyc[0] - g_cyc[0], 0);
    @(negedge clk);
    chk("t3_grant_gone", grant, 0);
    chk("t3_ticks", nticks, 0);
    // 4: abort by dropping req[3]; pending req[0] granted after idle cycle
    do_reset();
    set_dly(3, 5); req[3] = 1;
    wait_grant(3, 10);
    set_dly(0, 2); req[0] = 1;
    repeat (17) @(negedge clk);
    req[3] = 0;
    c = cyc;
    @(negedge clk);
    chk("t4_grant_cleared", grant, 0);
    chk("t4_busy_cleared", busy, 0);
    wait_done(0, 60, 1);
    chk("t4_done_count", d_own.size(), 1);
    chk("t4_done_owner", d_own[0], 0);
    chk("t4_next_owner", g_own[1], 0);
    chk("t4_next_cycle", g_cyc[1], c + 2);
    // 5: async reset mid-COUNT, then full 40-cycle restart
    do_reset();
    set_dly(2, 4); req[2] = 1;
    wait_grant(2, 10);
    repeat (12) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("t5_async_grant", grant, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_done", done, 0);
    chk("t5_async_tick", tick, 0);
    chk("t5_no_done", d_own.size(), 0);
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 0;
    wait_done(2, 100, 1);
    chk("t5_restart_lat", d_cyc[0] - g_cyc[0], 40);
    // 6: req[0] and req[1] held -> alternating grants, no starvation
    do_reset();
    set_dly(0, 1); set_dly(1, 1);
    req[0] = 1; req[1] = 1;
    ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (d_own.size() >= 8) ok = 1;
    end
    chk("t6_eight_done", ok, 1);
    req = '0;
    for (int k = 0; k < 8; k++) chk($sformatf("t6_alt%0d", k), g_own[k], k % 2);
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
